ghost_map_writer: RTL

- Downstream of the ghost location controller. Consumes its current and next ghost1/ghost2 grid positions and commits each move into the shared tile-map RAM.
- For every move it restores the tile each ghost was covering, captures the tile under each new position, and draws the ghost codes.
- Pulses wrdone so the location controller advances curr <= next. Flags a ghost landing on pacman's tile.
- Shares the map RAM with the pacman writer through a req/gnt handshake.

---
 rtl/ghost_map_writer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ghost_map_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ghost_map_writer                                             |
// | Description : Commits ghost1/ghost2 moves into the shared tile-map RAM:    |
// |               restores covered tiles, captures new ones, draws ghosts.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ghost_map_writer #(
   parameter int TILE_W      = 3,
   parameter int EMPTY_CODE  = 0,
   parameter int PACMAN_CODE = 3,
   parameter int GHOST1_CODE = 4,
   parameter int GHOST2_CODE = 5
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic [5:0]        curr_ghost1_x,
   input  logic [4:0]        curr_ghost1_y,
   input  logic [5:0]        curr_ghost2_x,
   input  logic [4:0]        curr_ghost2_y,
   input  logic [5:0]        next_ghost1_x,
   input  logic [4:0]        next_ghost1_y,
   input  logic [5:0]        next_ghost2_x,
   input  logic [4:0]        next_ghost2_y,
   input  logic              map_gnt,
   input  logic [TILE_W-1:0] map_rddata,
   output logic              map_req,
   output logic [5:0]        map_rdaddr_x,
   output logic [4:0]        map_rdaddr_y,
   output logic              map_wren,
   output logic [5:0]        map_wraddr_x,
   output logic [4:0]        map_wraddr_y,
   output logic [TILE_W-1:0] map_wrdata,
   output logic              wrdone,
   output logic [1:0]        ghost_hit,
   output logic              busy
);

   localparam logic [TILE_W-1:0] c_EMPTY  = TILE_W'(EMPTY_CODE);
   localparam logic [TILE_W-1:0] c_PACMAN = TILE_W'(PACMAN_CODE);
   localparam logic [TILE_W-1:0] c_GHOST1 = TILE_W'(GHOST1_CODE);
   localparam logic [TILE_W-1:0] c_GHOST2 = TILE_W'(GHOST2_CODE);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_REQ  = 4'd1,
      S_RST1 = 4'd2,
      S_RST2 = 4'd3,
      S_RD1  = 4'd4,
      S_RD2  = 4'd5,
      S_CAP2 = 4'd6,
      S_DRW1 = 4'd7,
      S_DRW2 = 4'd8,
      S_DONE = 4'd9
   } state_t;

   state_t            r_state;
   logic [5:0]        r_c1x, r_c2x, r_n1x, r_n2x;
   logic [4:0]        r_c1y, r_c2y, r_n1y, r_n2y;
   logic [TILE_W-1:0] r_under1, r_under2;
   logic [1:0]        r_hit;
   logic              w_start;

   assign w_start = (next_ghost1_x != curr_ghost1_x) || (next_ghost1_y != curr_ghost1_y) ||
                    (next_ghost2_x != curr_ghost2_x) || (next_ghost2_y != curr_ghost2_y);

   // Pacman and stale ghost codes must never be restored later, so they become blank.
   function automatic logic [TILE_W-1:0] f_stored(input logic [TILE_W-1:0] tile);
      if ((tile == c_PACMAN) || (tile == c_GHOST1) || (tile == c_GHOST2))
         return c_EMPTY;
      return tile;
   endfunction

   // Outputs are registered on the transition into the state they belong to.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_c1x        <= '0;
         r_c1y        <= '0;
         r_c2x        <= '0;
         r_c2y        <= '0;
         r_n1x        <= '0;
         r_n1y        <= '0;
         r_n2x        <= '0;
         r_n2y        <= '0;
         r_under1     <= c_EMPTY;
         r_under2     <= c_EMPTY;
         r_hit        <= '0;
         map_req      <= 1'b0;
         map_rdaddr_x <= '0;
         map_rdaddr_y <= '0;
         map_wren     <= 1'b0;
         map_wraddr_x <= '0;
         map_wraddr_y <= '0;
         map_wrdata   <= '0;
         wrdone       <= 1'b0;
         ghost_hit    <= '0;
         busy         <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_c1x   <= curr_ghost1_x;
                  r_c1y   <= curr_ghost1_y;
                  r_c2x   <= curr_ghost2_x;
                  r_c2y   <= curr_ghost2_y;
                  r_n1x   <= next_ghost1_x;
                  r_n1y   <= next_ghost1_y;
                  r_n2x   <= next_ghost2_x;
                  r_n2y   <= next_ghost2_y;
                  r_hit   <= '0;
                  map_req <= 1'b1;
                  busy    <= 1'b1;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               if (map_gnt) begin
                  map_wren     <= 1'b1;
                  map_wraddr_x <= r_c1x;
                  map_wraddr_y <= r_c1y;
                  map_wrdata   <= r_under1;
                  r_state      <= S_RST1;
               end
            end
            S_RST1: begin
               map_wraddr_x <= r_c2x;
               map_wraddr_y <= r_c2y;
               map_wrdata   <= r_under2;
               r_state      <= S_RST2;
            end
            S_RST2: begin
               map_wren     <= 1'b0;
               map_rdaddr_x <= r_n1x;
               map_rdaddr_y <= r_n1y;
               r_state      <= S_RD1;
            end
            S_RD1: begin
               map_rdaddr_x <= r_n2x;
               map_rdaddr_y <= r_n2y;
               r_state      <= S_RD2;
            end
            S_RD2: begin
               r_under1 <= f_stored(map_rddata);
               r_hit[0] <= (map_rddata == c_PACMAN);
               r_state  <= S_CAP2;
            end
            S_CAP2: begin
               r_under2     <= f_stored(map_rddata);
               r_hit[1]     <= (map_rddata == c_PACMAN);
               map_wren     <= 1'b1;
               map_wraddr_x <= r_n1x;
               map_wraddr_y <= r_n1y;
               map_wrdata   <= c_GHOST1;
               r_state      <= S_DRW1;
            end
            S_DRW1: begin
               map_wraddr_x <= r_n2x;
               map_wraddr_y <= r_n2y;
               map_wrdata   <= c_GHOST2;
               r_state      <= S_DRW2;
            end
            S_DRW2: begin
               map_wren  <= 1'b0;
               wrdone    <= 1'b1;
               ghost_hit <= r_hit;
               r_state   <= S_DONE;
            end
            S_DONE: begin
               wrdone    <= 1'b0;
               ghost_hit <= '0;
               map_req   <= 1'b0;
               busy      <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: begin
               map_wren <= 1'b0;
               wrdone   <= 1'b0;
               map_req  <= 1'b0;
               busy     <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
